// File: rtl/mux_pkg.sv
// Shared constants and types for the registered operand selector.
package mux_pkg;
  localparam int          MAX_MUX_IN      = 16;
  localparam logic [31:0] ILLEGAL_VAL_DEF = 32'h0;

  // Occupancy of the main + skid register pair.
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} fill_e;
endpackage

// File: rtl/mux_sel_comb.sv
// Combinational NUM_IN:1 selector with range check; out-of-range sel yields ILLEGAL_VAL.
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                NUM_IN      = 3,
  parameter int                SEL_W       = 2,
  parameter logic [WIDTH-1:0]  ILLEGAL_VAL = WIDTH'(ILLEGAL_VAL_DEF)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    illegal
);
  localparam int N_EFF = (NUM_IN > MAX_MUX_IN) ? MAX_MUX_IN : NUM_IN;

  always_comb begin
    data    = ILLEGAL_VAL;
    illegal = 1'b1;
    for (int k = 0; k < N_EFF; k++) begin
      if (32'(sel) == 32'(k)) begin
        data    = in_data[k*WIDTH +: WIDTH];
        illegal = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux_sel_pipe.sv
// Registered operand selector with valid/ready handshake, 2-entry skid buffer,
// per-beat illegal-select flag and sticky error.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                NUM_IN      = 3,
  parameter int                SEL_W       = 2,
  parameter logic [WIDTH-1:0]  ILLEGAL_VAL = WIDTH'(ILLEGAL_VAL_DEF)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  input  logic                    err_clr
);
  fill_e            state, state_nxt;
  logic [WIDTH-1:0] main_data, skid_data, sel_data;
  logic             main_err, skid_err, sel_ill;
  logic             in_ready_q;
  logic             acc, drain;
  logic             load_main_in, load_main_skid, load_skid;

  mux_sel_comb #(
    .WIDTH      (WIDTH),
    .NUM_IN     (NUM_IN),
    .SEL_W      (SEL_W),
    .ILLEGAL_VAL(ILLEGAL_VAL)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .data    (sel_data),
    .illegal (sel_ill)
  );

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_data;
  assign out_err   = main_err;
  assign acc       = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: if (acc) begin
        state_nxt    = ST_ONE;
        load_main_in = 1'b1;
      end
      ST_ONE: begin
        if (acc && drain) load_main_in = 1'b1;
        else if (acc) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (drain) state_nxt = ST_EMPTY;
      end
      ST_TWO: if (drain) begin
        state_nxt      = ST_ONE;
        load_main_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is precomputed from next occupancy so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
      if (load_main_in) begin
        main_data <= sel_data;
        main_err  <= sel_ill;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_ill;
      end
      if (acc && sel_ill) err_sticky <= 1'b1;
      else if (err_clr)   err_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench: directed tests on a 32-bit/3-input instance, random stress on it and a 5-bit/4-input one.
module tb_mux_sel_pipe;
  logic clk, reset_n;

  logic [95:0] a_in_data;
  logic [1:0]  a_sel;
  logic        a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready, a_err_sticky, a_err_clr;
  logic [31:0] a_out_data;

  logic [19:0] b_in_data;
  logic [1:0]  b_sel;
  logic        b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready, b_err_sticky, b_err_clr;
  logic [4:0]  b_out_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .err_sticky(a_err_sticky), .err_clr(a_err_clr));

  mux_sel_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .err_sticky(b_err_sticky), .err_clr(b_err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each block is a FIFO of at most two pending beats.
  typedef struct { logic [31:0] d; logic e; } beat_t;
  beat_t qa[$];
  beat_t qb[$];
  logic  sta, stb;

  always @(posedge clk) begin
    if (!reset_n) begin
      qa.delete(); qb.delete();
      sta <= 1'b0; stb <= 1'b0;
    end else begin
      automatic bit    acc_a = a_in_valid && qa.size() < 2;
      automatic bit    drn_a = qa.size() > 0 && a_out_ready;
      automatic bit    acc_b = b_in_valid && qb.size() < 2;
      automatic bit    drn_b = qb.size() > 0 && b_out_ready;
      automatic beat_t na, nb;
      if (a_sel < 2'd3) begin na.d = a_in_data[int'(a_sel)*32 +: 32]; na.e = 1'b0; end
      else              begin na.d = 32'h0;                           na.e = 1'b1; end
      nb.d = {27'h0, b_in_data[int'(b_sel)*5 +: 5]};
      nb.e = 1'b0;
      if (drn_a) void'(qa.pop_front());
      if (acc_a) qa.push_back(na);
      if (drn_b) void'(qb.pop_front());
      if (acc_b) qb.push_back(nb);
      if (acc_a && na.e) sta <= 1'b1; else if (a_err_clr) sta <= 1'b0;
      if (acc_b && nb.e) stb <= 1'b1; else if (b_err_clr) stb <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("a_valid", 32'(a_out_valid), 32'(qa.size() > 0));
      chk("a_ready", 32'(a_in_ready), 32'(qa.size() < 2));
      chk("a_sticky", 32'(a_err_sticky), 32'(sta));
      if (qa.size() > 0) begin
        chk("a_data", a_out_data, qa[0].d);
        chk("a_err", 32'(a_out_err), 32'(qa[0].e));
      end
      chk("b_valid", 32'(b_out_valid), 32'(qb.size() > 0));
      chk("b_ready", 32'(b_in_ready), 32'(qb.size() < 2));
      chk("b_sticky", 32'(b_err_sticky), 32'(stb));
      if (qb.size() > 0) begin
        chk("b_data", 32'(b_out_data), qb[0].d);
        chk("b_err", 32'(b_out_err), 32'(qb[0].e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_in_data = {32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    a_sel = '0; a_in_valid = 0; a_out_ready = 0; a_err_clr = 0;
    b_in_data = '0; b_sel = '0; b_in_valid = 0; b_out_ready = 0; b_err_clr = 0;

    // Reset and idle
    tick(); tick();
    chk("rst_valid", 32'(a_out_valid), 32'h0);
    chk("rst_ready", 32'(a_in_ready), 32'h1);
    chk("rst_sticky", 32'(a_err_sticky), 32'h0);
    chk("rst_data", a_out_data, 32'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Basic select, back to back
    a_out_ready = 1; a_in_valid = 1; a_sel = 2'd0;
    tick(); chk("sel0_data", a_out_data, 32'h0); chk("sel0_valid", 32'(a_out_valid), 32'h1);
    a_sel = 2'd1;
    tick(); chk("sel1_data", a_out_data, 32'h1); chk("model_front", qa[0].d, 32'h1);
    a_sel = 2'd2;
    tick(); chk("sel2_data", a_out_data, 32'h8000_0000); chk("sel2_err", 32'(a_out_err), 32'h0);
    a_in_valid = 0;
    tick(); chk("drained", 32'(a_out_valid), 32'h0);

    // Backpressure
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd1;
    tick(); chk("bp1_data", a_out_data, 32'h1); chk("bp1_ready", 32'(a_in_ready), 32'h1);
    a_sel = 2'd2;
    tick(); chk("bp2_ready", 32'(a_in_ready), 32'h0); chk("bp2_data", a_out_data, 32'h1);
    a_in_valid = 0;
    tick(); chk("bp_hold", a_out_data, 32'h1); chk("model_depth", 32'(qa.size()), 32'd2);
    a_out_ready = 1;
    tick(); chk("bp_drain_data", a_out_data, 32'h8000_0000); chk("bp_drain_ready", 32'(a_in_ready), 32'h1);
    tick(); chk("bp_empty", 32'(a_out_valid), 32'h0);

    // Illegal select and sticky error
    a_in_valid = 1; a_sel = 2'd3;
    tick(); chk("ill_data", a_out_data, 32'h0); chk("ill_err", 32'(a_out_err), 32'h1);
    chk("ill_sticky", 32'(a_err_sticky), 32'h1);
    a_in_valid = 0; a_err_clr = 1;
    tick(); chk("clr_sticky", 32'(a_err_sticky), 32'h0);
    a_in_valid = 1;
    tick(); chk("set_wins", 32'(a_err_sticky), 32'h1);
    a_in_valid = 0;
    tick(); chk("clr_again", 32'(a_err_sticky), 32'h0);
    a_err_clr = 0;
    tick();

    // Mid-operation reset
    a_out_ready = 0; a_in_valid = 1; a_sel = 2'd1;
    tick(); a_sel = 2'd2;
    tick(); chk("full_ready", 32'(a_in_ready), 32'h0);
    a_in_valid = 0; reset_n = 0;
    tick(); chk("mrst_valid", 32'(a_out_valid), 32'h0); chk("mrst_ready", 32'(a_in_ready), 32'h1);
    reset_n = 1; a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("mrst_no_beat", 32'(a_out_valid), 32'h0);
    end

    // Random stress on both instances
    for (int i = 0; i < 10000; i++) begin
      a_in_data   = {$urandom, $urandom, $urandom};
      a_sel       = 2'($urandom_range(0, 3));
      a_in_valid  = 1'($urandom);
      a_out_ready = 1'($urandom);
      a_err_clr   = ($urandom_range(0, 7) == 0);
      b_in_data   = 20'($urandom);
      b_sel       = 2'($urandom_range(0, 3));
      b_in_valid  = 1'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_err_clr   = 1'($urandom);
      tick();
    end
    a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    tick(); tick(); tick();
    chk("end_a_empty", 32'(a_out_valid), 32'h0);
    chk("end_b_empty", 32'(b_out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
